// File: rtl/edge_event_arbiter_pkg.sv
// Shared constants and small index helpers for the edge event arbiter slice.
package edge_event_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 9;

    // Adds an offset to a base index and wraps the sum into the range 0..width-1.
    // Requires base < width and off < width.
    function automatic int wrap_add(input int base, input int off, input int width);
        int sum;
        sum = base + off;
        return (sum >= width) ? (sum - width) : sum;
    endfunction

endpackage

// File: rtl/positive_edge_filter.sv
// Per-bit rising-edge detector. It raises rise[i] in the cycle where data_in[i]
// goes from 0 to 1.
module positive_edge_filter #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev_r;

    // Previous-sample register. It clears on reset, so a level that is
    // already high when reset ends counts as a fresh edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r <= {WIDTH{1'b0}};
        end else begin
            prev_r <= data_in;
        end
    end

    assign rise = data_in & ~prev_r;

endmodule

// File: rtl/edge_event_arbiter.sv
// Captures rising edges on WIDTH event lines as pending requests and grants them
// one at a time in round-robin order through a valid/ready handshake.
module edge_event_arbiter
    import edge_event_arbiter_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             en,
    input  logic             clr_ovf,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    input  logic             out_ready,
    output logic [WIDTH-1:0] pending,
    output logic [WIDTH-1:0] overflow
);

    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] pending_r;
    logic [WIDTH-1:0] overflow_r;
    logic             out_valid_r;
    logic [IDX_W-1:0] out_index_r;
    logic [IDX_W-1:0] rr_ptr_r;

    logic             load_s;
    logic [IDX_W-1:0] sel_s;
    logic [IDX_W-1:0] rr_next_s;
    logic [WIDTH-1:0] clear_s;
    logic [WIDTH-1:0] ovf_set_s;
    logic [WIDTH-1:0] pending_next_s;
    logic [WIDTH-1:0] overflow_next_s;

    positive_edge_filter #(
        .WIDTH (WIDTH)
    ) u_edge (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .rise    (rise_s)
    );

    // Returns the first set request at or above ptr, wrapping from WIDTH-1 to 0.
    // Callers use the result only when req is nonzero.
    function automatic logic [IDX_W-1:0] rr_search(input logic [WIDTH-1:0] req,
                                                   input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] result;
        logic [IDX_W-1:0] idx_v;
        logic             found;
        result = ptr;
        found  = 1'b0;
        for (int off = 0; off < WIDTH; off++) begin
            idx_v = IDX_W'(wrap_add(int'(ptr), off, WIDTH));
            if (!found && req[idx_v]) begin
                result = idx_v;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    // Decides the grant load and computes the next pending and overflow vectors.
    always_comb begin
        load_s    = en && (pending_r != {WIDTH{1'b0}}) && (!out_valid_r || out_ready);
        sel_s     = rr_search(pending_r, rr_ptr_r);
        rr_next_s = {IDX_W{1'b0}};
        clear_s   = {WIDTH{1'b0}};
        if (sel_s == IDX_W'(WIDTH - 1)) begin
            rr_next_s = {IDX_W{1'b0}};
        end else begin
            rr_next_s = sel_s + IDX_W'(1'b1);
        end
        if (load_s) begin
            clear_s[sel_s] = 1'b1;
        end else begin
            clear_s = {WIDTH{1'b0}};
        end
        // An edge on the bit being granted counts as a new event, not as a lost one.
        ovf_set_s      = rise_s & pending_r & ~clear_s;
        pending_next_s = (pending_r & ~clear_s) | rise_s;
        if (clr_ovf) begin
            overflow_next_s = ovf_set_s;
        end else begin
            overflow_next_s = overflow_r | ovf_set_s;
        end
    end

    // Holds the pending and overflow vectors, the grant register and the round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r   <= {WIDTH{1'b0}};
            overflow_r  <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_index_r <= {IDX_W{1'b0}};
            rr_ptr_r    <= {IDX_W{1'b0}};
        end else begin
            pending_r  <= pending_next_s;
            overflow_r <= overflow_next_s;
            if (load_s) begin
                out_valid_r <= 1'b1;
                out_index_r <= sel_s;
                rr_ptr_r    <= rr_next_s;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_index = out_index_r;
    assign pending   = pending_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter at WIDTH=9.
module tb_edge_event_arbiter;

    localparam int WIDTH = 9;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             en;
    logic             clr_ovf;
    logic             out_valid;
    logic [IDX_W-1:0] out_index;
    logic             out_ready;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] overflow;

    int checks = 0;
    int errors = 0;

    edge_event_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .en        (en),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_index (out_index),
        .out_ready (out_ready),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; data_in = 9'h000; en = 1'b1; clr_ovf = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        checks++; if (out_index !== 4'd0) begin errors++; $display("FAIL reset_index got %0d exp 0", out_index); end
        checks++; if (pending !== 9'h000) begin errors++; $display("FAIL reset_pending got %h exp 000", pending); end
        checks++; if (overflow !== 9'h000) begin errors++; $display("FAIL reset_overflow got %h exp 000", overflow); end
    endtask

    task automatic test_single();
        do_reset();
        data_in = 9'h001; tick();
        checks++; if (pending !== 9'h001) begin errors++; $display("FAIL single_pending got %h exp 001", pending); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd0) begin errors++; $display("FAIL single_grant got v%0b i%0d exp v1 i0", out_valid, out_index); end
        checks++; if (pending !== 9'h000) begin errors++; $display("FAIL single_pending_clr got %h exp 000", pending); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drop got %0b exp 0", out_valid); end
        data_in = 9'h000; tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        data_in = 9'h111; tick();
        checks++; if (pending !== 9'h111) begin errors++; $display("FAIL rr_pending got %h exp 111", pending); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd0) begin errors++; $display("FAIL rr_g0 got v%0b i%0d exp v1 i0", out_valid, out_index); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd4) begin errors++; $display("FAIL rr_g4 got v%0b i%0d exp v1 i4", out_valid, out_index); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd8 || pending !== 9'h000) begin errors++; $display("FAIL rr_g8 got v%0b i%0d p%h exp v1 i8 p000", out_valid, out_index, pending); end
        data_in = 9'h000; tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_idle got %0b exp 0", out_valid); end
        data_in = 9'h003; tick();
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd0) begin errors++; $display("FAIL rr_ptr_wrap got v%0b i%0d exp v1 i0", out_valid, out_index); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd1) begin errors++; $display("FAIL rr_next got v%0b i%0d exp v1 i1", out_valid, out_index); end
        data_in = 9'h000; tick();
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        data_in = 9'h004; tick();
        data_in = 9'h000; tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd2 || pending !== 9'h000) begin errors++; $display("FAIL ovf_hold got v%0b i%0d p%h exp v1 i2 p000", out_valid, out_index, pending); end
        data_in = 9'h004; tick();
        checks++; if (pending !== 9'h004 || overflow !== 9'h000) begin errors++; $display("FAIL ovf_first got p%h o%h exp p004 o000", pending, overflow); end
        data_in = 9'h000; tick();
        data_in = 9'h004; tick();
        checks++; if (pending !== 9'h004 || overflow !== 9'h004) begin errors++; $display("FAIL ovf_second got p%h o%h exp p004 o004", pending, overflow); end
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd2) begin errors++; $display("FAIL ovf_stable got v%0b i%0d exp v1 i2", out_valid, out_index); end
        data_in = 9'h000; clr_ovf = 1'b1; tick();
        checks++; if (overflow !== 9'h000) begin errors++; $display("FAIL ovf_clear got %h exp 000", overflow); end
        data_in = 9'h004; clr_ovf = 1'b1; tick();
        checks++; if (overflow !== 9'h004) begin errors++; $display("FAIL ovf_set_wins got %h exp 004", overflow); end
        data_in = 9'h000; clr_ovf = 1'b0; out_ready = 1'b1; tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd2 || pending !== 9'h000 || overflow !== 9'h004) begin errors++; $display("FAIL ovf_regrant got v%0b i%0d p%h o%h exp v1 i2 p000 o004", out_valid, out_index, pending, overflow); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain got %0b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        en = 1'b0; data_in = 9'h001; tick();
        checks++; if (pending !== 9'h001 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_accum got p%h v%0b exp p001 v0", pending, out_valid); end
        data_in = 9'h000; tick();
        en = 1'b1; data_in = 9'h001; tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd0 || pending !== 9'h001 || overflow !== 9'h000) begin errors++; $display("FAIL b2b_setclr got v%0b i%0d p%h o%h exp v1 i0 p001 o000", out_valid, out_index, pending, overflow); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd0 || pending !== 9'h000) begin errors++; $display("FAIL b2b_second got v%0b i%0d p%h exp v1 i0 p000", out_valid, out_index, pending); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop got %0b exp 0", out_valid); end
        data_in = 9'h000; tick();
    endtask

    task automatic test_wrap();
        do_reset();
        data_in = 9'h080; tick();
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd7) begin errors++; $display("FAIL wrap_g7 got v%0b i%0d exp v1 i7", out_valid, out_index); end
        en = 1'b0; data_in = 9'h181; tick();
        checks++; if (pending !== 9'h101 || out_valid !== 1'b0) begin errors++; $display("FAIL wrap_accept got p%h v%0b exp p101 v0", pending, out_valid); end
        en = 1'b1; tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd8) begin errors++; $display("FAIL wrap_g8 got v%0b i%0d exp v1 i8", out_valid, out_index); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd0 || pending !== 9'h000) begin errors++; $display("FAIL wrap_g0 got v%0b i%0d p%h exp v1 i0 p000", out_valid, out_index, pending); end
        data_in = 9'h000; tick();
    endtask

    task automatic test_enable();
        do_reset();
        en = 1'b0; data_in = 9'h0A2; tick();
        tick();
        checks++; if (out_valid !== 1'b0 || pending !== 9'h0A2) begin errors++; $display("FAIL en_off got v%0b p%h exp v0 p0a2", out_valid, pending); end
        en = 1'b1; tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd1) begin errors++; $display("FAIL en_g1 got v%0b i%0d exp v1 i1", out_valid, out_index); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd5) begin errors++; $display("FAIL en_g5 got v%0b i%0d exp v1 i5", out_valid, out_index); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd7 || pending !== 9'h000) begin errors++; $display("FAIL en_g7 got v%0b i%0d p%h exp v1 i7 p000", out_valid, out_index, pending); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL en_drain got %0b exp 0", out_valid); end
        data_in = 9'h000; tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0; data_in = 9'h003; tick();
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd0 || pending !== 9'h002) begin errors++; $display("FAIL mid_pre got v%0b i%0d p%h exp v1 i0 p002", out_valid, out_index, pending); end
        rst = 1'b1; data_in = 9'h010; tick();
        checks++; if (out_valid !== 1'b0 || out_index !== 4'd0 || pending !== 9'h000 || overflow !== 9'h000) begin errors++; $display("FAIL mid_reset got v%0b i%0d p%h o%h exp all 0", out_valid, out_index, pending, overflow); end
        rst = 1'b0; out_ready = 1'b1; tick();
        checks++; if (pending !== 9'h010 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_edge got p%h v%0b exp p010 v0", pending, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_index !== 4'd4) begin errors++; $display("FAIL mid_grant got v%0b i%0d exp v1 i4", out_valid, out_index); end
        data_in = 9'h000; tick();
    endtask

    initial begin
        rst = 1'b1; data_in = 9'h000; en = 1'b1; clr_ovf = 1'b0; out_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_back_to_back();
        test_wrap();
        test_enable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter WIDTH, default 9: number of event inputs; legal range 2..64.
REQ-002 Derived constant IDX_W, value $clog2(WIDTH): width of the grant index.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 data_in  input  WIDTH: level-type event sources; a 0->1 transition on bit i is one event for source i.
REQ-006 en  input  1: grant enable; events are captured regardless of en.
REQ-007 clr_ovf  input  1: single-cycle pulse that clears all overflow flags.
REQ-008 out_valid  output  1: a granted event index is presented.
REQ-009 out_index  output  IDX_W: index of the granted source.
REQ-010 out_ready  input  1: consumer accepts the grant when out_valid && out_ready.
REQ-011 pending  output  WIDTH: captured events not yet granted.
REQ-012 overflow  output  WIDTH: sticky per-source lost-event flags.

Function
REQ-013 Edge detection: edge[i] = data_in[i] & ~prev[i], with prev = data_in registered each cycle.
REQ-014 An edge in cycle N sets pending[i] at the clock edge ending cycle N.
REQ-015 Load condition: en && (pending != 0) && (!out_valid || out_ready).
REQ-016 On load: select the first set pending bit at or after rr_ptr, searching upward and wrapping from WIDTH-1 to 0.
REQ-017 On load: register the selected index into out_index, set out_valid=1, clear pending of that index, and set rr_ptr = (index+1) mod WIDTH.
REQ-018 If there is no load and out_valid && out_ready, clear out_valid.
REQ-019 While out_valid && !out_ready, out_valid and out_index hold stable.
REQ-020 Minimum latency: data_in rises in cycle N, pending is set in N+1, out_valid asserts in N+2.
REQ-021 Throughput: one grant per cycle when out_ready is held high.
REQ-022 Simultaneous set and clear on the same bit (edge on the index being loaded): pending stays 1 and no overflow is raised.
REQ-023 An edge on bit i while pending[i]=1 and bit i is not being loaded sets overflow[i]; pending[i] stays 1 (events merge).
REQ-024 An edge on the index currently held in out_index (already removed from pending) is a new event, not an overflow.
REQ-025 clr_ovf clears all overflow bits; a same-cycle overflow set wins for that bit.
REQ-026 When en=0, no new load occurs, but a held grant may still be accepted; pending accumulates.
REQ-027 rr_ptr changes only on load.

Reset
REQ-028 On rst: prev=0, pending=0, overflow=0, out_valid=0, out_index=0, rr_ptr=0.
REQ-029 Reset mid-operation discards any held grant and all pending events.
REQ-030 A data_in bit that is high during reset produces an edge in the first cycle after reset, since prev=0.

Structure
REQ-031 Edge detection is one instance of the existing positive_edge_filter sub-module, WIDTH-wide, sharing clk and rst.
REQ-032 No shared package types are needed; IDX_W is computed locally.
REQ-033 The round-robin search is a combinational function within this module.

Verification (WIDTH=9)
REQ-034 data_in 0->0x001, out_ready=1 -> out_valid=1 with out_index=0 exactly two cycles later for one cycle; pending returns to 0.
REQ-035 data_in 0->0x111 in one cycle, out_ready=1 -> grants 0, 4, 8 on consecutive cycles; then rr_ptr=0.
REQ-036 Hold out_ready=0 with grant 2 held; pulse data_in[2] twice more -> first pulse sets pending[2], second sets overflow[2]; clr_ovf clears it.
REQ-037 rr_ptr=8 with pending=0x101 -> next grant is 8, then 0 (wrap-around).
REQ-038 en=0 with three edges -> no out_valid, pending=3 bits; en=1 -> three grants in round-robin order.
REQ-039 Assert rst with out_valid=1 and pending nonzero -> next cycle all outputs are 0; a held-high data_in bit is granted two cycles after rst deasserts.
